// File: rtl/spi_pkg.sv
// Shared widths, constants and FSM state type for the SPI frame receiver.
package spi_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W  = $clog2(MAX_W + 1);

    localparam logic RW_READ = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        RW,
        RD_LOAD,
        RD_SHIFT,
        WR_DATA,
        WR_COMMIT,
        WAIT_CS
    } spi_state_t;

endpackage

// File: rtl/spi_frame_receiver_if.sv
// Conditioned SPI pad inputs, memory port and MISO pad controls of the frame receiver.
interface spi_frame_receiver_if;
    import spi_pkg::*;

    logic              cs_n;
    logic              sclk_pos;
    logic              sclk_neg;
    logic              mosi;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              rd_req;
    logic              miso;
    logic              miso_oe;

    modport slave (
        input  cs_n, sclk_pos, sclk_neg, mosi, rd_data,
        output addr, wr_data, wr_en, rd_req, miso, miso_oe
    );

    modport master (
        output cs_n, sclk_pos, sclk_neg, mosi, rd_data,
        input  addr, wr_data, wr_en, rd_req, miso, miso_oe
    );

endinterface

// File: rtl/shift_reg_sipo_piso.sv
// Parallel-load shift register; shifts left with serial input or zero fill, MSB is the serial output.
module shift_reg_sipo_piso #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_shift_in_en,
    input  logic         i_sin,
    input  logic         i_shift_out_en,
    output logic [W-1:0] o_q,
    output logic         o_sout
);

    logic [W-1:0] r_q;

    // Load wins over shift-in, shift-in wins over shift-out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_load_data;
        end else if (i_shift_in_en) begin
            r_q <= {r_q[W-2:0], i_sin};
        end else if (i_shift_out_en) begin
            r_q <= {r_q[W-2:0], 1'b0};
        end
    end

    assign o_q    = r_q;
    assign o_sout = r_q[W-1];

endmodule

// File: rtl/spi_frame_receiver.sv
// Decodes address / R-W / data SPI frames into single-cycle memory write and read requests.
module spi_frame_receiver
    import spi_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    spi_frame_receiver_if.slave  bus
);

    spi_state_t        r_state;
    spi_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_wr_en;
    logic              r_rd_req;
    logic              r_miso;
    logic              r_miso_oe;

    logic              w_pos;
    logic              w_neg;
    logic              w_in_shift;
    logic              w_addr_load;
    logic              w_commit;
    logic              w_rd_fire;
    logic              w_out_load;
    logic              w_out_shift;
    logic              w_miso_oe_next;

    logic [DATA_W-1:0] w_in_q;
    logic              w_in_sout_unused;
    logic [DATA_W-1:0] w_out_q_unused;
    logic              w_out_sout;

    // A rising edge masks a coincident falling edge.
    assign w_pos = bus.sclk_pos;
    assign w_neg = bus.sclk_neg & ~bus.sclk_pos;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_in_shift     = 1'b0;
        w_addr_load    = 1'b0;
        w_commit       = 1'b0;
        w_rd_fire      = 1'b0;
        w_out_load     = 1'b0;
        w_out_shift    = 1'b0;
        w_miso_oe_next = 1'b0;

        // Chip-select release aborts any frame; a commit already under way still issues.
        if (r_state != IDLE && bus.cs_n) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_commit     = (r_state == WR_COMMIT);
        end else begin
            case (r_state)
                IDLE: begin
                    if (!bus.cs_n) begin
                        w_state_next = ADDR;
                        w_cnt_next   = '0;
                    end
                end
                ADDR: begin
                    if (w_pos) begin
                        w_in_shift = 1'b1;
                        w_cnt_next = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(ADDR_W - 1)) begin
                            w_addr_load  = 1'b1;
                            w_state_next = RW;
                        end
                    end
                end
                RW: begin
                    if (w_pos) begin
                        if (bus.mosi == RW_READ) begin
                            w_rd_fire    = 1'b1;
                            w_state_next = RD_LOAD;
                        end else begin
                            w_state_next = WR_DATA;
                            w_cnt_next   = '0;
                        end
                    end
                end
                RD_LOAD: begin
                    w_out_load     = 1'b1;
                    w_miso_oe_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = RD_SHIFT;
                end
                RD_SHIFT: begin
                    w_miso_oe_next = 1'b1;
                    if (w_pos) begin
                        if (r_cnt == CNT_W'(DATA_W)) begin
                            w_miso_oe_next = 1'b0;
                            w_state_next   = WAIT_CS;
                        end
                    end else if (w_neg && r_cnt != CNT_W'(DATA_W)) begin
                        w_out_shift = 1'b1;
                        w_cnt_next  = r_cnt + CNT_W'(1);
                    end
                end
                WR_DATA: begin
                    if (w_pos) begin
                        w_in_shift = 1'b1;
                        w_cnt_next = r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(DATA_W - 1)) begin
                            w_state_next = WR_COMMIT;
                        end
                    end
                end
                WR_COMMIT: begin
                    w_commit     = 1'b1;
                    w_state_next = WAIT_CS;
                end
                WAIT_CS: begin
                    w_state_next = WAIT_CS;
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // Registered memory-side and pad-side outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr    <= '0;
            r_wr_data <= '0;
            r_wr_en   <= 1'b0;
            r_rd_req  <= 1'b0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
        end else begin
            if (w_addr_load) begin
                r_addr <= {w_in_q[ADDR_W-2:0], bus.mosi};
            end
            if (w_commit) begin
                r_wr_data <= w_in_q;
            end
            if (w_out_shift) begin
                r_miso <= w_out_sout;
            end
            r_wr_en   <= w_commit;
            r_rd_req  <= w_rd_fire;
            r_miso_oe <= w_miso_oe_next;
        end
    end

    shift_reg_sipo_piso #(.W(DATA_W)) u_in_shift (
        .clk            (clk),
        .reset          (reset),
        .i_load         (1'b0),
        .i_load_data    ('0),
        .i_shift_in_en  (w_in_shift),
        .i_sin          (bus.mosi),
        .i_shift_out_en (1'b0),
        .o_q            (w_in_q),
        .o_sout         (w_in_sout_unused)
    );

    shift_reg_sipo_piso #(.W(DATA_W)) u_out_shift (
        .clk            (clk),
        .reset          (reset),
        .i_load         (w_out_load),
        .i_load_data    (bus.rd_data),
        .i_shift_in_en  (1'b0),
        .i_sin          (1'b0),
        .i_shift_out_en (w_out_shift),
        .o_q            (w_out_q_unused),
        .o_sout         (w_out_sout)
    );

    assign bus.addr    = r_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_en   = r_wr_en;
    assign bus.rd_req  = r_rd_req;
    assign bus.miso    = r_miso;
    assign bus.miso_oe = r_miso_oe;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Scoreboard bench for spi_frame_receiver: directed and random frames against a memory reference model.
module tb_spi_frame_receiver;
    import spi_pkg::*;

    typedef struct {
        bit         is_rd;
        logic [6:0] addr;
        logic [7:0] data;
        int         due;
    } txn_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    spi_frame_receiver_if bus();

    logic [7:0] ref_mem [128];
    logic [7:0] dut_mem [128];
    txn_t       exp_q [$];
    logic       miso_q [$];
    bit         oe_window;

    bit   pend;
    logic pend_bit;
    bit   oe_prev;

    spi_frame_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.rd_data = dut_mem[bus.addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: samples outputs on the falling clock edge and pops expectations.
    always @(negedge clk) begin
        txn_t e;
        if (reset) begin
            pend    = 1'b0;
            oe_prev = 1'b0;
        end else begin
            if (pend) begin
                pend = 1'b0;
                check("miso_oe_during_bit", 32'(bus.miso_oe), 32'(1));
                check("miso_bit", 32'(bus.miso), 32'(pend_bit));
            end
            if (bus.sclk_neg && !bus.sclk_pos && oe_window && miso_q.size() > 0) begin
                pend     = 1'b1;
                pend_bit = miso_q.pop_front();
            end
            if (bus.miso_oe && !oe_prev) begin
                check("miso_oe_rise_in_read", 32'(oe_window), 32'(1));
            end
            oe_prev = bus.miso_oe;
            if (bus.wr_en) begin
                check("wr_en_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("wr_en_kind_is_read", 32'(e.is_rd), 32'(0));
                    check("wr_addr", 32'(bus.addr), 32'(e.addr));
                    check("wr_data", 32'(bus.wr_data), 32'(e.data));
                    check("wr_en_latency", 32'(cyc), 32'(e.due));
                end
                dut_mem[bus.addr] = bus.wr_data;
            end
            if (bus.rd_req) begin
                check("rd_req_expected", 32'(exp_q.size() > 0), 32'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rd_req_kind_is_read", 32'(e.is_rd), 32'(1));
                    check("rd_addr", 32'(bus.addr), 32'(e.addr));
                    check("rd_req_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_setup(input logic b, input int half);
        bus.mosi = b;
        repeat (half - 1) tick();
    endtask

    task automatic pulse_pos(input bit both);
        bus.sclk_pos = 1'b1;
        bus.sclk_neg = both;
        tick();
        bus.sclk_pos = 1'b0;
        bus.sclk_neg = 1'b0;
    endtask

    task automatic bit_fall(input int half);
        repeat (half - 1) tick();
        bus.sclk_neg = 1'b1;
        tick();
        bus.sclk_neg = 1'b0;
    endtask

    task automatic end_frame();
        bus.cs_n  = 1'b1;
        oe_window = 1'b0;
        tick();
        check("miso_oe_after_frame", 32'(bus.miso_oe), 32'(0));
    endtask

    // One frame of 7 address bits, R/W and 8 data bits, SCLK mode 0.
    task automatic frame(input logic [6:0] a, input logic rw, input logic [7:0] d, input int half,
                         input int abort_at, input int extra, input int both_bit, input int rst_at);
        logic [15:0] bits;
        logic        b;
        bits = {a, rw, d};
        bus.cs_n = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                end_frame();
                return;
            end
            b = bits[15 - i];
            if (rw == RW_READ && i >= 8) b = 1'($urandom_range(0, 1));
            bit_setup(b, half);
            if (i == 7 && rw == RW_READ) begin
                exp_q.push_back('{is_rd: 1'b1, addr: a, data: ref_mem[a], due: cyc + 1});
                for (int k = 7; k >= 0; k--) miso_q.push_back(ref_mem[a][k]);
                oe_window = 1'b1;
            end
            if (i == 15 && rw != RW_READ) begin
                exp_q.push_back('{is_rd: 1'b0, addr: a, data: d, due: cyc + 2});
                ref_mem[a] = d;
            end
            pulse_pos(i == both_bit);
            bit_fall(half);
            if (rw == RW_READ && i >= 8 && (i - 8) == rst_at) begin
                #2;
                reset = 1'b1;
                #1;
                check("async_rst_addr", 32'(bus.addr), 32'(0));
                check("async_rst_wr_data", 32'(bus.wr_data), 32'(0));
                check("async_rst_wr_en", 32'(bus.wr_en), 32'(0));
                check("async_rst_rd_req", 32'(bus.rd_req), 32'(0));
                check("async_rst_miso", 32'(bus.miso), 32'(0));
                check("async_rst_miso_oe", 32'(bus.miso_oe), 32'(0));
                miso_q.delete();
                oe_window    = 1'b0;
                bus.cs_n     = 1'b1;
                bus.sclk_pos = 1'b0;
                bus.sclk_neg = 1'b0;
                repeat (2) tick();
                reset = 1'b0;
                tick();
                return;
            end
        end
        repeat (extra) begin
            bit_setup(1'($urandom_range(0, 1)), half);
            pulse_pos(1'b0);
            bit_fall(half);
        end
        end_frame();
    endtask

    initial begin
        logic [6:0] ra;
        logic       rrw;
        logic [7:0] rd;
        int         rab;
        int         rboth;

        checks       = 0;
        errors       = 0;
        cyc          = 0;
        oe_window    = 1'b0;
        reset        = 1'b1;
        bus.cs_n     = 1'b1;
        bus.sclk_pos = 1'b0;
        bus.sclk_neg = 1'b0;
        bus.mosi     = 1'b0;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = 8'($urandom);
            dut_mem[i] = ref_mem[i];
        end
        ref_mem[7'h12] = 8'hC6;
        dut_mem[7'h12] = 8'hC6;

        repeat (2) tick();
        check("reset_addr", 32'(bus.addr), 32'(0));
        check("reset_wr_data", 32'(bus.wr_data), 32'(0));
        check("reset_wr_en", 32'(bus.wr_en), 32'(0));
        check("reset_rd_req", 32'(bus.rd_req), 32'(0));
        check("reset_miso", 32'(bus.miso), 32'(0));
        check("reset_miso_oe", 32'(bus.miso_oe), 32'(0));
        reset = 1'b0;
        repeat (2) tick();

        frame(7'h55, 1'b0, 8'hA3, 3, -1, 4, -1, -1);
        frame(7'h12, 1'b1, 8'h00, 3, -1, 4, -1, -1);
        frame(7'h55, 1'b0, 8'h77, 3, 13, 0, -1, -1);
        frame(7'h01, 1'b0, 8'hFF, 3, -1, 0, -1, -1);
        frame(7'h01, 1'b1, 8'h00, 2, -1, 0, -1, -1);
        frame(7'h33, 1'b1, 8'h00, 3, -1, 0, -1, 1);
        frame(7'h7F, 1'b1, 8'h00, 3, -1, 2, -1, -1);
        frame(7'h10, 1'b0, 8'h3C, 2, -1, 4, -1, -1);
        frame(7'h10, 1'b1, 8'h00, 2, -1, 4, -1, -1);
        frame(7'h2A, 1'b0, 8'h96, 3, -1, 0, 11, -1);
        frame(7'h2A, 1'b1, 8'h00, 3, -1, 0, -1, -1);

        for (int n = 0; n < 40; n++) begin
            ra  = 7'($urandom_range(0, 127));
            rrw = 1'($urandom_range(0, 1));
            rd  = 8'($urandom);
            rab = -1;
            if ($urandom_range(0, 5) == 0) begin
                rab = (rrw == RW_READ) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
            end
            rboth = -1;
            if (rrw != RW_READ && $urandom_range(0, 2) == 0) rboth = int'($urandom_range(8, 15));
            frame(ra, rrw, rd, int'($urandom_range(2, 4)), rab, int'($urandom_range(0, 4)), rboth, -1);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (6) tick();
        check("expected_txns_drained", 32'(exp_q.size()), 32'(0));
        check("expected_miso_bits_drained", 32'(miso_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_receiver.md
Name: spi_frame_receiver

Overview:
- Consumes the conditioned outputs of three input conditioners (chip select, serial clock, MOSI) and decodes SPI-style frames into memory read/write transactions.
- Sits between the input-conditioning stage and the data memory; drives MISO back to the pad logic.
- Frame: 7-bit address MSB-first, then R/W bit (1 = read), then 8 data bits (write: in on MOSI; read: out on MISO).

Parameters:
- addrwidth, 7, address bits per frame.
- datawidth, 8, data bits per frame.

Ports:
- clk  in  1  system clock; all inputs are synchronous to it.
- reset  in  1  asynchronous, active-high reset.
- cs_n  in  1  conditioned chip-select level, active low.
- sclk_pos  in  1  one-clk pulse at a conditioned SCLK rising edge.
- sclk_neg  in  1  one-clk pulse at a conditioned SCLK falling edge.
- mosi  in  1  conditioned MOSI level.
- rd_data  in  datawidth  memory read data; combinational from addr, valid in the cycle after rd_req.
- addr  out  addrwidth  latched frame address.
- wr_data  out  datawidth  latched write data.
- wr_en  out  1  one-clk write strobe.
- rd_req  out  1  one-clk read request.
- miso  out  1  serial read data.
- miso_oe  out  1  MISO output enable (buffer tristate control).

Behaviour:
- Reset (async, active-high): state IDLE. addr = 0, wr_data = 0, wr_en = 0, rd_req = 0, miso = 0, miso_oe = 0, bit counter = 0, shift registers = 0.
- States: IDLE, ADDR, RW, RD_LOAD, RD_SHIFT, WR_DATA, WR_COMMIT, WAIT_CS.
- IDLE: when cs_n = 0, go to ADDR with counter = 0.
- ADDR: on each sclk_pos, shift mosi into the address register LSB (MSB-first on the wire) and increment the counter. After addrwidth bits, go to RW.
- RW: on sclk_pos, sample mosi.
  - mosi = 1: pulse rd_req for 1 clk and go to RD_LOAD.
  - mosi = 0: go to WR_DATA with counter = 0.
  - addr updates exactly once per frame, on the cycle RW is entered.
- RD_LOAD: exactly 1 clk. Load rd_data into the output shift register, set miso_oe = 1, go to RD_SHIFT.
- RD_SHIFT:
  - On each sclk_neg, drive miso = current MSB, then shift left.
  - After datawidth sclk_neg pulses, hold miso at the last bit and go to WAIT_CS on the next sclk_pos.
  - miso_oe stays 1 until WAIT_CS.
  - The first bit appears on the first sclk_neg after the RW rising edge.
- WR_DATA: on each sclk_pos, shift mosi in. After datawidth bits, go to WR_COMMIT.
- WR_COMMIT: exactly 1 clk. wr_data is updated on entry and wr_en = 1 for that cycle; then go to WAIT_CS.
- WAIT_CS: ignore sclk and mosi. miso_oe = 0. When cs_n = 1, go to IDLE.
- cs_n = 1 in any non-IDLE state:
  - Next clk to IDLE; counter cleared; miso_oe = 0.
  - No wr_en if the abort happens before WR_COMMIT.
  - A wr_en already in flight in WR_COMMIT completes.
- sclk_pos and sclk_neg both high in one cycle (illegal): sclk_pos takes priority; sclk_neg is ignored.
- Extra SCLK edges after a frame completes have no effect until cs_n toggles high, then low.
- Width rules: counter width = clog2(max(addrwidth, datawidth) + 1). Counter saturation never occurs because the state exits at terminal count.
- Latency:
  - Write: wr_en asserts 2 clks after the sclk_pos pulse of the last data bit.
  - Read: rd_req asserts 1 clk after the R/W sclk_pos pulse.

Decomposition:
- Shared package spi_pkg:
  - state enum spi_state_t.
  - ADDR_W = 7, DATA_W = 8.
  - RW_READ = 1'b1.
- One natural sub-module: shift_reg_sipo_piso, a parallel-load, serial-in/serial-out shift register with separate shift-in and shift-out enables.
  - Instantiated twice: address/write-data input, and read-data output.
- FSM and counter stay in the top module.

Test Plan:
- Write frame: cs_n low; addr 0x55, rw = 0, data 0xA3; cs_n high. -> Single 1-clk wr_en with addr = 0x55 and wr_data = 0xA3; rd_req never asserts; miso_oe stays 0.
- Read frame: addr 0x12, rw = 1, rd_data model returns 0xC6. -> rd_req pulses once, 1 clk after the R/W sclk_pos. miso on successive sclk_neg is 1,1,0,0,0,1,1,0; miso_oe = 1 only during the data phase.
- Abort: cs_n high after 5 write-data bits. -> No wr_en; FSM returns to IDLE within 1 clk. The next full frame (addr 0x01, data 0xFF) writes correctly.
- Async reset mid-read (during bit 3 of RD_SHIFT). -> All outputs are 0 immediately, with no clk edge needed. The following read of addr 0x7F works.
- Back-to-back frames with a 1-clk cs_n high gap: write 0x10 ← 0x3C, then read 0x10. -> wr_en precedes rd_req; the read returns 0x3C; 4 extra SCLK pulses after each frame produce no transactions.
- Simultaneous sclk_pos and sclk_neg during WR_DATA. -> The bit is captured once; the final wr_data matches the MOSI stream.
